// File: rtl/ptosda_sched.sv
// ptosda_sched: round-robin scheduler sharing one 4-bit SDA/SCL frame
// serializer between four requesters. The serializer is held in reset while
// idle, loaded with the winner's nibble, released for exactly one frame, and
// reset again once the frame's stop condition (or a timeout) is seen.
//
// Parameters:
//   TIMEOUT  sclk cycles allowed in WAIT_ACK and in SEND before abort
//   GAP      minimum cycles the serializer is held in reset between frames (>=1)
// Ports:
//   sclk       clock, all logic on posedge
//   rst        asynchronous active-low reset
//   req        per-requester request level
//   req_data   nibble per requester, requester i on [4i+3:4i]
//   grant      one-hot owner of the current frame, 0 when idle
//   done       one-cycle pulse on the owner's bit when its frame stopped
//   err        one-cycle pulse when a frame is aborted by timeout
//   ser_rst_n  active-low reset to the serializer
//   ser_data   nibble presented to the serializer
//   ser_ack    serializer ack; rising edge means ser_data was latched
//   ser_scl    serializer SCL (observed)
//   ser_sda    serializer SDA (observed)
module ptosda_sched #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP     = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] req_data,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        err,
  output logic        ser_rst_n,
  output logic [3:0]  ser_data,
  input  logic        ser_ack,
  input  logic        ser_scl,
  input  logic        ser_sda
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    WAIT_ACK = 3'd2,
    SEND     = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5,
    GAPW     = 3'd6
  } state_t;

  localparam logic [6:0] TO_LAST  = 7'(TIMEOUT - 1);
  localparam logic [6:0] GAP_LAST = 7'(GAP - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [6:0]  cnt, cnt_nxt;
  logic        ack_q, scl_q, sda_q;

  logic [3:0]  grant_nxt, done_nxt, ser_data_nxt;
  logic        err_nxt, ser_rst_n_nxt;

  logic [1:0]  win, cand;
  logic [3:0]  nib;
  logic        ack_rise, stop;

  assign ack_rise = ser_ack & ~ack_q;
  // SDA rising while SCL stays high; a falling SDA (start) never matches.
  assign stop     = ~sda_q & ser_sda & scl_q & ser_scl;

  // Rotating-priority search: walk offsets 3..0 from ptr so the smallest
  // offset with a set request is the last (winning) assignment.
  always_comb begin
    win  = ptr;
    cand = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + 2'(3 - k);
      if (req[cand]) win = cand;
    end
    case (win)
      2'd0:    nib = req_data[3:0];
      2'd1:    nib = req_data[7:4];
      2'd2:    nib = req_data[11:8];
      default: nib = req_data[15:12];
    endcase
  end

  // State register plus registered outputs.
  always_ff @(posedge sclk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      idx       <= '0;
      cnt       <= '0;
      ack_q     <= 1'b0;
      scl_q     <= 1'b1;
      sda_q     <= 1'b1;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      ser_rst_n <= 1'b0;
      ser_data  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      ack_q     <= ser_ack;
      scl_q     <= ser_scl;
      sda_q     <= ser_sda;
      grant     <= grant_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      ser_rst_n <= ser_rst_n_nxt;
      ser_data  <= ser_data_nxt;
    end
  end

  // Next-state and internal register updates.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ptr_nxt   = ptr;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (|req) begin
          idx_nxt   = win;
          state_nxt = ARM;
        end
      end
      ARM: begin
        cnt_nxt   = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_rise) begin
          cnt_nxt   = '0;
          state_nxt = SEND;
        end else if (cnt == TO_LAST) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + 7'd1;
        end
      end
      SEND: begin
        // Stop is checked first so it wins over a simultaneous timeout.
        if (stop) begin
          state_nxt = DONE;
        end else if (cnt == TO_LAST) begin
          state_nxt = ERR;
        end else begin
          cnt_nxt = cnt + 7'd1;
        end
      end
      DONE, ERR: begin
        ptr_nxt   = idx + 2'd1;
        cnt_nxt   = '0;
        state_nxt = GAPW;
      end
      GAPW: begin
        cnt_nxt = cnt + 7'd1;
        if (cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = GAPW;
      end
    endcase
  end

  // Next values of the registered outputs; data/grant hold unless changed.
  always_comb begin
    grant_nxt     = grant;
    ser_data_nxt  = ser_data;
    ser_rst_n_nxt = ser_rst_n;
    done_nxt      = '0;
    err_nxt       = 1'b0;
    case (state)
      IDLE: begin
        ser_rst_n_nxt = 1'b0;
        if (|req) begin
          grant_nxt    = 4'b0001 << win;
          ser_data_nxt = nib;
        end
      end
      ARM: begin
        ser_rst_n_nxt = 1'b1;
      end
      WAIT_ACK, SEND: begin
      end
      DONE: begin
        done_nxt      = 4'b0001 << idx;
        ser_rst_n_nxt = 1'b0;
        grant_nxt     = '0;
      end
      ERR: begin
        err_nxt       = 1'b1;
        ser_rst_n_nxt = 1'b0;
        grant_nxt     = '0;
      end
      GAPW: begin
        ser_rst_n_nxt = 1'b0;
      end
      default: begin
        ser_rst_n_nxt = 1'b0;
        grant_nxt     = '0;
      end
    endcase
  end

endmodule
